bus_master_port: RTL and testbench
==================================

Name: bus_master_port

Overview:
- Master-side endpoint of the serial system bus; the initiator counterpart to the arbiter.
- Accepts one read or write command at a time from a local master.
- Requests the bus from the arbiter with a slave select and waits for grant.
- Serially shifts address and write data out MSB-first, or shifts read data in, then releases the request.

Parameters:
- ADDR_WIDTH, 12, address bits shifted per transaction.
- DATA_WIDTH, 8, data bits per transaction.
- SLAVE_SEL_WIDTH, 2, width of slave select presented to arbiter.
- TIMEOUT_CYCLES, 64, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle command strobe; sampled only in IDLE.
- rw  in  1  1 = write, 0 = read; latched on accepted start.
- addr  in  ADDR_WIDTH  target address; latched on start.
- wdata  in  DATA_WIDTH  write data; latched on start.
- slave_sel  in  SLAVE_SEL_WIDTH  target slave; latched on start.
- busy  out  1  high from the cycle after accept until DONE completes.
- done  out  1  one-cycle completion pulse.
- error  out  1  valid with done; timeout flag.
- rdata  out  DATA_WIDTH  read result; updated at DONE for reads only.
- m_request  out  1  bus request to arbiter.
- m_slave_select  out  SLAVE_SEL_WIDTH  latched slave_sel, driven while m_request is high, else 0.
- m_grant  in  1  grant from arbiter.
- bus_out  out  1  serial address/write-data line.
- bus_out_valid  out  1  qualifies bus_out.
- bus_mode  out  1  latched rw while granted, else 0.
- bus_in  in  1  serial read data from slave.
- bus_in_valid  in  1  qualifies bus_in.
- slave_ready  in  1  slave write acknowledge.

Behaviour:
- Reset (asynchronous, reset = 0):
  - State goes to IDLE.
  - All outputs are 0, including rdata and error.
  - Counters and latched command are cleared.
  - Reset mid-transfer aborts immediately; no done pulse.
- IDLE:
  - start = 1 latches rw, addr, wdata and slave_sel, then goes to REQ.
  - start in any other state is ignored and dropped silently.
- REQ:
  - m_request = 1 and busy = 1 in the first REQ cycle, so 1 cycle after start.
  - Stays in REQ until m_grant is sampled 1, then goes to ADDR.
- ADDR:
  - Drives addr MSB-first, one bit per cycle, with bus_out_valid = 1, for ADDR_WIDTH cycles.
  - The first bit appears in the cycle after the grant is sampled.
  - Afterwards goes to WDATA if rw = 1, else RDATA.
- WDATA:
  - Drives wdata MSB-first for DATA_WIDTH cycles with bus_out_valid = 1, then goes to WAIT_ACK.
- WAIT_ACK:
  - bus_out_valid = 0.
  - slave_ready sampled 1 moves to DONE.
  - slave_ready asserted in any other state is ignored.
- RDATA:
  - Shifts bus_in in MSB-first, only on cycles with bus_in_valid = 1.
  - Gaps are allowed.
  - After DATA_WIDTH valid bits, goes to DONE.
- DONE:
  - Lasts exactly one cycle: done = 1, m_request = 0, bus_out_valid = 0.
  - For reads, rdata takes the assembled word.
  - Next state is IDLE; busy falls with the move to IDLE.
  - A start in the IDLE cycle right after DONE is accepted.
- m_request:
  - High continuously from REQ through ADDR, WDATA, RDATA and WAIT_ACK.
  - Never toggles mid-transaction.
- Grant withdrawn (m_grant = 0 sampled in ADDR, WDATA, RDATA or WAIT_ACK):
  - bus_out_valid drops next cycle and bit counters clear.
  - Returns to REQ with m_request still high.
  - The whole transaction is replayed from the first address bit on re-grant.
- Bit counters: sized clog2(max(ADDR_WIDTH, DATA_WIDTH)) + 1; no wrap inside a phase.

Optional Feature:
- Macro: BUS_MASTER_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in REQ, RDATA and WAIT_ACK and clears on every state change.
  - When the counter reaches TIMEOUT_CYCLES, the block goes to DONE with done = 1 and error = 1; rdata is unchanged and m_request drops.
- Not defined:
  - No counter is built and error is tied to 0.
  - The block waits indefinitely in REQ, RDATA and WAIT_ACK.

Test Plan:
- Write: rw=1, addr=0xA5C, wdata=0x3C, slave_sel=2, grant 3 cycles after m_request, slave_ready 2 cycles after the last data bit.
  -> bus_out sequence 101001011100 then 00111100 with valid high for 20 cycles; m_slave_select=2; one done pulse; error=0.
- Read: rw=0, addr=0x001; slave sends 0xC3 with one idle gap in bus_in_valid.
  -> 12 address bits on bus_out, bus_mode=0, rdata=0xC3 at done.
- start pulsed while busy during ADDR.
  -> Ignored; exactly one done pulse; latched addr and data unchanged.
- m_grant dropped after 5 address bits, restored 4 cycles later.
  -> bus_out_valid low during the gap; address replayed from the MSB; completes normally.
- reset driven low during WDATA.
  -> All outputs 0 immediately; no done pulse; a new start afterwards completes normally.
- With BUS_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=64, m_grant never asserted.
  -> done=1 and error=1 after 64 REQ cycles, then m_request=0.

Source files
------------

// File: rtl/bus_master_port.sv
// bus_master_port: master-side endpoint of the serial system bus.
// Takes one read/write command from a local master and requests the bus
// from the arbiter. Once granted, it shifts the address (and write data)
// out MSB-first, or shifts read data in. It then completes with a
// one-cycle done pulse.
// Optional watchdog: define BUS_MASTER_TIMEOUT_EN to abort a transaction
// stuck in REQ, RDATA or WAIT_ACK for TIMEOUT_CYCLES cycles (done + error).
module bus_master_port #(
  parameter int ADDR_WIDTH      = 12,
  parameter int DATA_WIDTH      = 8,
  parameter int SLAVE_SEL_WIDTH = 2,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       rw,
  input  logic [ADDR_WIDTH-1:0]      addr,
  input  logic [DATA_WIDTH-1:0]      wdata,
  input  logic [SLAVE_SEL_WIDTH-1:0] slave_sel,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [DATA_WIDTH-1:0]      rdata,
  output logic                       m_request,
  output logic [SLAVE_SEL_WIDTH-1:0] m_slave_select,
  input  logic                       m_grant,
  output logic                       bus_out,
  output logic                       bus_out_valid,
  output logic                       bus_mode,
  input  logic                       bus_in,
  input  logic                       bus_in_valid,
  input  logic                       slave_ready
);

  localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_W = $clog2(MAX_W) + 1;
  localparam int TX_W  = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_ADDR, S_WDATA, S_WAIT_ACK, S_RDATA, S_DONE
  } state_t;

  state_t state_reg, state_next;

  // Latched command; kept intact so a withdrawn grant can replay it.
  logic                       rw_reg;
  logic [ADDR_WIDTH-1:0]      addr_reg;
  logic [DATA_WIDTH-1:0]      wdata_reg;
  logic [SLAVE_SEL_WIDTH-1:0] sel_reg;

  // Working registers for the serial phases.
  logic [TX_W-1:0]       tx_reg;
  logic [CNT_W-1:0]      bit_cnt_reg;
  logic [DATA_WIDTH-2:0] rx_reg;
  logic [DATA_WIDTH-1:0] rx_word;
  logic [DATA_WIDTH-1:0] rdata_reg;

  // Control strobes from the FSM to the datapath.
  logic load_cmd, load_tx, shift_tx, bit_clr, bit_inc, rx_en, rdata_load;
  logic tmo_hit, tmo_fire;

  assign rx_word = {rx_reg, bus_in};

`ifdef BUS_MASTER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt_reg;
  logic             err_reg;

  // Watchdog: counts cycles spent in a waiting state, restarts on any state change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt_reg <= '0;
    end else if (state_next != state_reg) begin
      tmo_cnt_reg <= '0;
    end else if (state_reg inside {S_REQ, S_RDATA, S_WAIT_ACK}) begin
      tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
    end
  end

  // Error flag: set by a watchdog abort, cleared by the next accepted command.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_reg <= 1'b0;
    end else if (load_cmd) begin
      err_reg <= 1'b0;
    end else if (tmo_fire) begin
      err_reg <= 1'b1;
    end
  end

  assign tmo_hit = (tmo_cnt_reg == TMO_LAST);
  assign error   = done & err_reg;
`else
  // Keeps TIMEOUT_CYCLES referenced in builds without the watchdog.
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYCLES;
  assign tmo_hit    = 1'b0;
  assign error      = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic, control strobes and Moore outputs.
  always_comb begin
    state_next    = state_reg;
    load_cmd      = 1'b0;
    load_tx       = 1'b0;
    shift_tx      = 1'b0;
    bit_clr       = 1'b0;
    bit_inc       = 1'b0;
    rx_en         = 1'b0;
    rdata_load    = 1'b0;
    tmo_fire      = 1'b0;
    busy          = (state_reg != S_IDLE);
    done          = 1'b0;
    m_request     = 1'b0;
    bus_out       = 1'b0;
    bus_out_valid = 1'b0;
    bus_mode      = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          load_cmd   = 1'b1;
          state_next = S_REQ;
        end
      end
      S_REQ: begin
        m_request = 1'b1;
        if (m_grant) begin
          load_tx    = 1'b1;
          bit_clr    = 1'b1;
          state_next = S_ADDR;
        end else if (tmo_hit) begin
          tmo_fire   = 1'b1;
          state_next = S_DONE;
        end
      end
      S_ADDR: begin
        m_request     = 1'b1;
        bus_out       = tx_reg[TX_W-1];
        bus_out_valid = 1'b1;
        bus_mode      = rw_reg;
        if (!m_grant) begin
          bit_clr    = 1'b1;
          state_next = S_REQ;
        end else begin
          shift_tx = 1'b1;
          if (bit_cnt_reg == ADDR_LAST) begin
            bit_clr    = 1'b1;
            state_next = rw_reg ? S_WDATA : S_RDATA;
          end else begin
            bit_inc = 1'b1;
          end
        end
      end
      S_WDATA: begin
        m_request     = 1'b1;
        bus_out       = tx_reg[TX_W-1];
        bus_out_valid = 1'b1;
        bus_mode      = rw_reg;
        if (!m_grant) begin
          bit_clr    = 1'b1;
          state_next = S_REQ;
        end else begin
          shift_tx = 1'b1;
          if (bit_cnt_reg == DATA_LAST) begin
            bit_clr    = 1'b1;
            state_next = S_WAIT_ACK;
          end else begin
            bit_inc = 1'b1;
          end
        end
      end
      S_WAIT_ACK: begin
        m_request = 1'b1;
        bus_mode  = rw_reg;
        if (!m_grant) begin
          bit_clr    = 1'b1;
          state_next = S_REQ;
        end else if (slave_ready) begin
          state_next = S_DONE;
        end else if (tmo_hit) begin
          tmo_fire   = 1'b1;
          state_next = S_DONE;
        end
      end
      S_RDATA: begin
        m_request = 1'b1;
        bus_mode  = rw_reg;
        if (!m_grant) begin
          bit_clr    = 1'b1;
          state_next = S_REQ;
        end else if (bus_in_valid) begin
          rx_en = 1'b1;
          if (bit_cnt_reg == DATA_LAST) begin
            rdata_load = 1'b1;
            bit_clr    = 1'b1;
            state_next = S_DONE;
          end else begin
            bit_inc = 1'b1;
          end
        end else if (tmo_hit) begin
          tmo_fire   = 1'b1;
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Datapath: command latch, transmit shifter, bit counter, receive assembly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rw_reg      <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      sel_reg     <= '0;
      tx_reg      <= '0;
      bit_cnt_reg <= '0;
      rx_reg      <= '0;
      rdata_reg   <= '0;
    end else begin
      if (load_cmd) begin
        rw_reg    <= rw;
        addr_reg  <= addr;
        wdata_reg <= wdata;
        sel_reg   <= slave_sel;
      end
      // Reloaded on every grant so a replay restarts from the address MSB.
      if (load_tx) begin
        tx_reg <= {addr_reg, wdata_reg};
      end else if (shift_tx) begin
        tx_reg <= {tx_reg[TX_W-2:0], 1'b0};
      end
      if (bit_clr) begin
        bit_cnt_reg <= '0;
      end else if (bit_inc) begin
        bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
      end
      if (rx_en) begin
        rx_reg <= rx_word[DATA_WIDTH-2:0];
      end
      if (rdata_load) begin
        rdata_reg <= rx_word;
      end
    end
  end

  assign rdata          = rdata_reg;
  assign m_slave_select = m_request ? sel_reg : '0;

endmodule

// File: tb/tb_bus_master_port.sv
// Testbench for bus_master_port: a behavioural arbiter and slave drive
// randomized transactions. Observed serial traffic, done/rdata and
// handshake outputs are compared against expectations derived from the
// command fields.
module tb_bus_master_port;

  localparam int AW  = 12;
  localparam int DW  = 8;
  localparam int SW  = 2;
  localparam int TMO = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          rw = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [SW-1:0] slave_sel = '0;
  logic          busy, done, error;
  logic [DW-1:0] rdata;
  logic          m_request;
  logic [SW-1:0] m_slave_select;
  logic          m_grant = 1'b0;
  logic          bus_out, bus_out_valid, bus_mode;
  logic          bus_in = 1'b0;
  logic          bus_in_valid = 1'b0;
  logic          slave_ready = 1'b0;

  int            checks = 0;
  int            failures = 0;
  logic [DW-1:0] model_rdata = '0;

  always #5 clk = ~clk;

  bus_master_port #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SLAVE_SEL_WIDTH(SW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
    .slave_sel(slave_sel), .busy(busy), .done(done), .error(error), .rdata(rdata),
    .m_request(m_request), .m_slave_select(m_slave_select), .m_grant(m_grant),
    .bus_out(bus_out), .bus_out_valid(bus_out_valid), .bus_mode(bus_mode),
    .bus_in(bus_in), .bus_in_valid(bus_in_valid), .slave_ready(slave_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction with a behavioural arbiter/slave.
  // drop_at / busy_start_at / rst_at: bit count at which to withdraw grant,
  // pulse a spurious start, or assert reset (-1 disables).
  task automatic run_txn(input string name, input logic t_rw, input logic [AW-1:0] t_addr,
                         input logic [DW-1:0] t_wdata, input logic [SW-1:0] t_sel,
                         input logic [DW-1:0] t_rd, input int grant_dly, input int ack_dly,
                         input int drop_at, input int busy_start_at, input int rst_at);
    bit exp_q[$];
    bit got_q[$];
    int done_cnt = 0;
    int req_wait = 0;
    int gap_left = 0;
    int sent = 0;
    int ack_wait = 0;
    int mism = -1;
    bit dropped = 0, gap_taken = 0, ack_sent = 0, bs_done = 0;
    bit finished = 0, aborted = 0;
    logic [SW-1:0] exp_sel;
    for (int i = AW - 1; i >= 0; i--) exp_q.push_back(t_addr[i]);
    if (t_rw) for (int i = DW - 1; i >= 0; i--) exp_q.push_back(t_wdata[i]);

    start = 1'b1; rw = t_rw; addr = t_addr; wdata = t_wdata; slave_sel = t_sel;
    tick();
    start = 1'b0;
    // scramble command inputs: the DUT must use its latched copy
    rw = 1'($urandom); addr = AW'($urandom); wdata = DW'($urandom); slave_sel = SW'($urandom);
    checks++;
    if (busy !== 1'b1 || m_request !== 1'b1) begin
      failures++;
      $display("FAIL %s accept: busy=%b m_request=%b required 1 1", name, busy, m_request);
    end

    for (int cyc = 0; cyc < 400; cyc++) begin
      // ---- sample phase ----
      if (done === 1'b1) begin
        done_cnt++;
        if (!t_rw) model_rdata = t_rd;
      end
      exp_sel = m_request ? t_sel : '0;
      checks++;
      if (m_slave_select !== exp_sel) begin
        failures++;
        $display("FAIL %s slave_select: got %0d required %0d", name, m_slave_select, exp_sel);
      end
      checks++;
      if (rdata !== model_rdata) begin
        failures++;
        $display("FAIL %s rdata: got %h required %h", name, rdata, model_rdata);
      end
      checks++;
      if (error !== 1'b0) begin
        failures++;
        $display("FAIL %s error: got %b required 0", name, error);
      end
      if (done_cnt == 0 && done !== 1'b1) begin
        checks++;
        if (m_request !== 1'b1) begin
          failures++;
          $display("FAIL %s request_hold: got %b required 1", name, m_request);
        end
      end
      if (done === 1'b1) begin
        checks++;
        if (m_request !== 1'b0 || bus_out_valid !== 1'b0) begin
          failures++;
          $display("FAIL %s done_outputs: m_request=%b bus_out_valid=%b required 0 0",
                   name, m_request, bus_out_valid);
        end
      end
      if (bus_out_valid === 1'b1) begin
        checks++;
        if (bus_mode !== t_rw) begin
          failures++;
          $display("FAIL %s bus_mode: got %b required %b", name, bus_mode, t_rw);
        end
        got_q.push_back(bus_out);
      end
      if (done_cnt > 0 && done !== 1'b1) begin
        checks++;
        if (busy !== 1'b0) begin
          failures++;
          $display("FAIL %s busy_after_done: got %b required 0", name, busy);
        end
        finished = 1;
        break;
      end
      if (rst_at >= 0 && got_q.size() == rst_at) begin
        reset = 1'b0;
        #1;
        checks++;
        if ({busy, done, error, rdata, m_request, m_slave_select, bus_out, bus_out_valid,
             bus_mode} !== '0) begin
          failures++;
          $display("FAIL %s reset_outputs: busy=%b done=%b req=%b valid=%b rdata=%h required all 0",
                   name, busy, done, m_request, bus_out_valid, rdata);
        end
        model_rdata = '0;
        m_grant = 1'b0; slave_ready = 1'b0; bus_in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
          tick();
          checks++;
          if (done !== 1'b0 || m_request !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s after_reset: done=%b req=%b busy=%b required 0 0 0",
                     name, done, m_request, busy);
          end
        end
        aborted = 1;
        finished = 1;
        break;
      end

      // ---- drive phase: arbiter ----
      if (m_request !== 1'b1) begin
        m_grant = 1'b0;
      end else if (m_grant == 1'b0) begin
        if (gap_left > 0) begin
          checks++;
          if (bus_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s grant_gap_valid: got %b required 0", name, bus_out_valid);
          end
          gap_left--;
          if (gap_left == 0) begin
            m_grant = 1'b1;
            got_q.delete();
            sent = 0;
          end
        end else begin
          if (req_wait >= grant_dly) m_grant = 1'b1;
          req_wait++;
        end
      end else if (drop_at >= 0 && !dropped && got_q.size() == drop_at) begin
        for (int i = 0; i < drop_at; i++) if (got_q[i] != exp_q[i] && mism < 0) mism = i;
        checks++;
        if (mism >= 0) begin
          failures++;
          $display("FAIL %s pre_drop_bits: bit %0d got %b required %b", name, mism,
                   got_q[mism], exp_q[mism]);
        end
        m_grant = 1'b0;
        dropped = 1;
        gap_left = 4;
      end

      // ---- drive phase: local master spurious start ----
      start = 1'b0;
      if (busy_start_at >= 0 && !bs_done && got_q.size() == busy_start_at) begin
        start = 1'b1; rw = ~t_rw; addr = ~t_addr; wdata = ~t_wdata; slave_sel = ~t_sel;
        bs_done = 1;
      end

      // ---- drive phase: slave ----
      slave_ready = 1'b0;
      if (t_rw) begin
        if (got_q.size() == AW + DW && m_grant && !ack_sent) begin
          if (ack_wait >= ack_dly) begin
            slave_ready = 1'b1;
            ack_sent = 1;
          end
          ack_wait++;
        end else if (got_q.size() < AW + DW) begin
          slave_ready = ($urandom_range(0, 3) == 0);
        end
      end else begin
        slave_ready = ($urandom_range(0, 3) == 0);
      end
      bus_in_valid = 1'b0;
      bus_in = 1'($urandom_range(0, 1));
      if (!t_rw && m_grant && got_q.size() == AW && bus_out_valid !== 1'b1 && sent < DW) begin
        if (sent == 3 && !gap_taken) begin
          gap_taken = 1;
        end else if ($urandom_range(0, 3) != 0) begin
          bus_in_valid = 1'b1;
          bus_in = t_rd[DW-1-sent];
          sent++;
        end
      end
      tick();
    end

    start = 1'b0; slave_ready = 1'b0; bus_in_valid = 1'b0;
    checks++;
    if (!finished) begin
      failures++;
      $display("FAIL %s timeout: no completion within cycle budget, done_cnt=%0d required 1",
               name, done_cnt);
    end
    if (!aborted) begin
      checks++;
      if (done_cnt != 1) begin
        failures++;
        $display("FAIL %s done_count: got %0d required 1", name, done_cnt);
      end
      mism = -1;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
        if (got_q[i] != exp_q[i] && mism < 0) mism = i;
      checks++;
      if (got_q.size() != exp_q.size() || mism >= 0) begin
        failures++;
        $display("FAIL %s serial_bits: got %0d bits (first diff %0d) required %0d bits",
                 name, got_q.size(), mism, exp_q.size());
      end
    end else begin
      checks++;
      if (done_cnt != 0) begin
        failures++;
        $display("FAIL %s aborted_done: got %0d pulses required 0", name, done_cnt);
      end
    end
    $display("txn %-12s rw=%0d addr=%h wdata=%h sel=%0d bits=%0d done=%0d rdata=%h%s",
             name, t_rw, t_addr, t_wdata, t_sel, got_q.size(), done_cnt, rdata,
             aborted ? " (reset)" : "");
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if ({busy, done, error, rdata, m_request, m_slave_select, bus_out, bus_out_valid,
         bus_mode} !== '0) begin
      failures++;
      $display("FAIL reset_state: busy=%b req=%b valid=%b rdata=%h required all 0",
               busy, m_request, bus_out_valid, rdata);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || m_request !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: busy=%b req=%b done=%b required 0 0 0", busy, m_request, done);
    end
    $display("txn reset        outputs idle");
  endtask

  task automatic test_write();
    run_txn("write", 1'b1, 12'hA5C, 8'h3C, 2'd2, 8'h00, 3, 2, -1, -1, -1);
  endtask

  task automatic test_read();
    run_txn("read", 1'b0, 12'h001, 8'h00, 2'd1, 8'hC3, 1, 1, -1, -1, -1);
  endtask

  task automatic test_start_while_busy();
    run_txn("start_busy", 1'b1, 12'h35A, 8'h96, 2'd3, 8'h00, 0, 2, -1, 3, -1);
  endtask

  task automatic test_grant_drop();
    run_txn("grant_drop", 1'b1, 12'hC71, 8'h5A, 2'd1, 8'h00, 2, 1, 5, -1, -1);
  endtask

  task automatic test_reset_mid_write();
    run_txn("reset_wdata", 1'b1, 12'h8F0, 8'hE7, 2'd2, 8'h00, 1, 1, -1, -1, AW + 3);
    run_txn("post_reset", 1'b0, 12'h7E3, 8'h00, 2'd3, 8'h5D, 2, 1, -1, -1, -1);
  endtask

  task automatic test_back_to_back();
    run_txn("b2b_first", 1'b0, 12'h123, 8'h00, 2'd0, 8'hA9, 0, 1, -1, -1, -1);
    run_txn("b2b_second", 1'b1, 12'hFED, 8'h81, 2'd1, 8'h00, 0, 1, -1, -1, -1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      run_txn("random", 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
              SW'($urandom), DW'($urandom), $urandom_range(0, 4), $urandom_range(1, 4),
              -1, -1, -1);
    end
  endtask

`ifdef BUS_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    int  reqc = 0;
    bit  seen = 0;
    logic [DW-1:0] before;
    before = rdata;
    m_grant = 1'b0;
    start = 1'b1; rw = 1'b0; addr = 12'h2B4; slave_sel = 2'd1;
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (done === 1'b1) begin
        seen = 1;
        checks++;
        if (error !== 1'b1 || m_request !== 1'b0 || rdata !== before || reqc != TMO) begin
          failures++;
          $display("FAIL timeout_done: error=%b req=%b rdata=%h req_cycles=%0d required 1 0 %h %0d",
                   error, m_request, rdata, reqc, before, TMO);
        end
        break;
      end
      if (m_request === 1'b1) reqc++;
      tick();
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL timeout_missing: no done within budget, req_cycles=%0d required %0d", reqc, TMO);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || m_request !== 1'b0 || error !== 1'b0) begin
      failures++;
      $display("FAIL timeout_idle: busy=%b req=%b error=%b required 0 0 0", busy, m_request, error);
    end
    $display("txn timeout      req_cycles=%0d done_seen=%0d", reqc, seen);
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_start_while_busy();
    test_grant_drop();
    test_reset_mid_write();
    test_back_to_back();
    test_random();
`ifdef BUS_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
